unidade_controle_multiciclo: RTL and testbench

Multicycle main control FSM for the MIPS datapath. Decodes the instruction register opcode and funct, sequences fetch, decode, execute, memory and writeback phases with a memory-ready handshake, and drives every datapath control line. It is the producer side of the `ULAOp` interface: it drives `ULAOp` into the ALU control unit, which expands it with funct into the ALU operation.

---
 rtl/unidade_controle_multiciclo_pkg.sv | 62 ++++++
 rtl/unidade_controle_multiciclo_saidas.sv | 79 +++++++
 rtl/unidade_controle_multiciclo.sv | 105 ++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// ALU-control selectors and the bundled control-output word.
package unidade_controle_multiciclo_pkg;

   typedef enum logic [3:0] {
      S_RESET     = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXEC_R    = 4'd7,
      S_R_WB      = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_JR        = 4'd11,
      S_EXEC_I    = 4'd12,
      S_I_WB      = 4'd13
   } estado_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] FUNCT_JR = 6'b001000;

   localparam logic [1:0] ULA_RTYPE = 2'b00;
   localparam logic [1:0] ULA_SUB   = 2'b01;
   localparam logic [1:0] ULA_SLT   = 2'b10;
   localparam logic [1:0] ULA_ADD   = 2'b11;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_RS     = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ior_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [1:0] ula_op;
   } ctrl_t;

endpackage

// File: rtl/unidade_controle_multiciclo_saidas.sv
// Pure combinational decoder from FSM state (plus mem_ready in FETCH) to the
// datapath control word; anything not set below stays 0.
module controle_saidas
   import unidade_controle_multiciclo_pkg::*;
(
   input  estado_t estado,
   input  logic    mem_ready,
   input  logic    slti,
   output ctrl_t   ctrl
);

   always_comb begin
      ctrl = '0;
      case (estado)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ula_op    = ULA_ADD;
            ctrl.pc_source = PCSRC_ALU;
            // IR and PC only latch on the cycle the fetch actually completes
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
            ctrl.ula_op    = ULA_ADD;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.ula_op    = ULA_ADD;
         end
         S_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.ior_d    = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.ior_d     = 1'b1;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.ula_op    = ULA_RTYPE;
         end
         S_R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_EXEC_I: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.ula_op    = slti ? ULA_SLT : ULA_ADD;
         end
         S_I_WB: ctrl.reg_write = 1'b1;
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.ula_op        = ULA_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         S_JR: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_RS;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS main control: state register, next-state sequencing with
// memory-ready handshake, retired-instruction counter and invalid-op flag.
module unidade_controle_multiciclo
   import unidade_controle_multiciclo_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic        IRWrite,
   output logic        RegDst,
   output logic        RegWrite,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSource,
   output logic [1:0]  ULAOp,
   output logic [3:0]  estado,
   output logic        invalid_op,
   output logic [31:0] instr_count
);

   estado_t state, next;
   ctrl_t   ctrl;
   logic    valid_op, slti, count_en;

   always_comb begin
      valid_op = 1'b0;
      case (opcode)
         OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI: valid_op = 1'b1;
         default: valid_op = 1'b0;
      endcase
   end

   assign slti = (opcode == OP_SLTI);

   always_comb begin
      next = state;
      case (state)
         S_RESET:  next = S_FETCH;
         S_FETCH:  next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:     next = S_MEM_ADDR;
               OP_R:             next = (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
               OP_BEQ:           next = S_BRANCH;
               OP_J:             next = S_JUMP;
               OP_ADDI, OP_SLTI: next = S_EXEC_I;
               default:          next = S_FETCH;
            endcase
         end
         S_MEM_ADDR:  next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  next = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: next = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_EXEC_R:    next = S_R_WB;
         S_EXEC_I:    next = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JR: next = S_FETCH;
         default:     next = S_RESET;
      endcase
   end

   // DECODE->FETCH is only the invalid-opcode path, so it never retires
   assign count_en = (next == S_FETCH) &&
                     !(state inside {S_RESET, S_FETCH, S_DECODE});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_RESET;
         instr_count <= '0;
      end else begin
         state <= next;
         if (count_en) instr_count <= instr_count + 32'd1;
      end
   end

   controle_saidas u_saidas (
      .estado    (state),
      .mem_ready (mem_ready),
      .slti      (slti),
      .ctrl      (ctrl)
   );

   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign IorD        = ctrl.ior_d;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign IRWrite     = ctrl.ir_write;
   assign RegDst      = ctrl.reg_dst;
   assign RegWrite    = ctrl.reg_write;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign PCSource    = ctrl.pc_source;
   assign ULAOp       = ctrl.ula_op;
   assign estado      = state;
   assign invalid_op  = (state == S_DECODE) && !valid_op;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Randomized bench: each instruction is expanded into its expected per-cycle
// phase list, then the DUT is compared cycle by cycle against that list.
module tb_unidade_controle_multiciclo;

   logic        clk = 1'b0, rst_n = 1'b1, mem_ready = 1'b0;
   logic [5:0]  opcode = '0, funct = '0;
   logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
   logic        RegDst, RegWrite, ALUSrcA, invalid_op;
   logic [1:0]  ALUSrcB, PCSource, ULAOp;
   logic [3:0]  estado;
   logic [31:0] instr_count;

   unidade_controle_multiciclo dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .ULAOp(ULAOp), .estado(estado), .invalid_op(invalid_op), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   localparam int RST = 0, F = 1, D = 2, MA = 3, MR = 4, MWB = 5, MW = 6,
                  EXR = 7, RWB = 8, BR = 9, JMP = 10, JRS = 11, EXI = 12, IWB = 13;

   int          n_tests = 0, n_fail = 0;
   logic [31:0] cnt;
   wire  [15:0] ctrl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                            IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ULAOp};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Control word each phase is expected to show, straight from the phase table.
   function automatic logic [15:0] exp_ctrl(input int st, input logic rdy, input logic is_slti);
      logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rwr, srca;
      logic [1:0] srcb, pcs, ula;
      {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rwr, srca} = '0;
      srcb = 2'b00; pcs = 2'b00; ula = 2'b00;
      case (st)
         F:   begin mrd = 1; srcb = 2'b01; ula = 2'b11; irw = rdy; pcw = rdy; end
         D:   begin srcb = 2'b11; ula = 2'b11; end
         MA:  begin srca = 1; srcb = 2'b10; ula = 2'b11; end
         MR:  begin mrd = 1; iord = 1; end
         MWB: begin rwr = 1; m2r = 1; end
         MW:  begin mwr = 1; iord = 1; end
         EXR: begin srca = 1; end
         RWB: begin rwr = 1; rdst = 1; end
         EXI: begin srca = 1; srcb = 2'b10; ula = is_slti ? 2'b10 : 2'b11; end
         IWB: begin rwr = 1; end
         BR:  begin srca = 1; ula = 2'b01; pcwc = 1; pcs = 2'b01; end
         JMP: begin pcw = 1; pcs = 2'b10; end
         JRS: begin pcw = 1; pcs = 2'b11; end
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rwr, srca, srcb, pcs, ula};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; mem_ready = 1'b1;
      repeat (2) begin
         @(negedge clk); #1;
         chk("rst_estado", 32'(estado), 0);
         chk("rst_ctrl", 32'(ctrl_obs), 0);
         chk("rst_inv", 32'(invalid_op), 0);
         chk("rst_count", instr_count, 0);
      end
      rst_n = 1'b1; #1;
      chk("rel_estado", 32'(estado), RST);
      cnt = '0;
   endtask

   // wf/wm: wait cycles in fetch and in the data access; abort_at: phase index
   // at which reset is yanked mid-instruction (-1 = run to completion).
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int wf, input int wm, input int abort_at);
      int ph[$];
      bit rq[$];
      bit ok = 1'b1;
      logic is_slti = (op == 6'b001010);
      for (int i = 0; i < wf; i++) begin ph.push_back(F); rq.push_back(0); end
      ph.push_back(F); rq.push_back(1);
      ph.push_back(D); rq.push_back(0);
      case (op)
         6'b100011: begin
            ph.push_back(MA); rq.push_back(0);
            for (int i = 0; i < wm; i++) begin ph.push_back(MR); rq.push_back(0); end
            ph.push_back(MR); rq.push_back(1);
            ph.push_back(MWB); rq.push_back(0);
         end
         6'b101011: begin
            ph.push_back(MA); rq.push_back(0);
            for (int i = 0; i < wm; i++) begin ph.push_back(MW); rq.push_back(0); end
            ph.push_back(MW); rq.push_back(1);
         end
         6'b000000: begin
            if (fn == 6'b001000) begin ph.push_back(JRS); rq.push_back(0); end
            else begin ph.push_back(EXR); rq.push_back(0); ph.push_back(RWB); rq.push_back(0); end
         end
         6'b000100: begin ph.push_back(BR); rq.push_back(0); end
         6'b000010: begin ph.push_back(JMP); rq.push_back(0); end
         6'b001000, 6'b001010: begin
            ph.push_back(EXI); rq.push_back(0); ph.push_back(IWB); rq.push_back(0);
         end
         default: ok = 1'b0;
      endcase
      foreach (ph[k]) begin
         @(negedge clk);
         mem_ready = (ph[k] inside {F, MR, MW}) ? rq[k] : 1'($urandom);
         if (ph[k] inside {D, MA, EXI}) begin opcode = op; funct = fn; end
         else begin opcode = 6'($urandom); funct = 6'($urandom); end
         #1;
         chk("estado", 32'(estado), 32'(ph[k]));
         chk("ctrl", 32'(ctrl_obs), 32'(exp_ctrl(ph[k], rq[k], is_slti)));
         chk("invalid_op", 32'(invalid_op), 32'(ph[k] == D && !ok));
         chk("instr_count", instr_count, cnt);
         if (k == abort_at) begin
            rst_n = 1'b0; #1;
            chk("abort_estado", 32'(estado), 0);
            chk("abort_memwrite", 32'(MemWrite), 0);
            chk("abort_count", instr_count, 0);
            cnt = '0;
            return;
         end
      end
      if (ok) cnt++;
   endtask

   logic [5:0] op_tab [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                              6'b000010, 6'b001000, 6'b001010, 6'b111111};

   initial begin
      cnt = '0;
      #2;
      do_reset();
      run_instr(6'b000000, 6'b100000, 0, 0, -1);    // R add
      run_instr(6'b100011, 6'b000000, 0, 2, -1);    // lw, 2 wait cycles
      run_instr(6'b000100, 6'b000000, 0, 0, -1);    // beq
      run_instr(6'b000010, 6'b000000, 0, 0, -1);    // j
      run_instr(6'b000000, 6'b001000, 0, 0, -1);    // jr
      run_instr(6'b111111, 6'b000000, 0, 0, -1);    // invalid
      run_instr(6'b101011, 6'b000000, 1, 3, 5);     // sw, reset in 2nd write-wait cycle
      do_reset();
      run_instr(6'b001000, 6'b000000, 0, 0, -1);
      // previous addi retires on the coming edge: FFFFFFFE -> FFFFFFFF
      force dut.instr_count = 32'hFFFF_FFFE;
      #1 release dut.instr_count;
      cnt = 32'hFFFF_FFFF;
      run_instr(6'b001000, 6'b000000, 0, 0, -1);    // addi wraps count to 0
      run_instr(6'b001010, 6'b000000, 2, 0, -1);    // slti
      chk("wrap_count", cnt, 32'd1);
      for (int n = 0; n < 80; n++) begin
         logic [5:0] op, fn;
         op = op_tab[$urandom_range(0, 7)];
         fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
         run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), -1);
      end
      @(negedge clk); #1;
      chk("final_count", instr_count, cnt);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
